// File: rtl/projectile_pkg.sv
// projectile_pkg: shared state/mode encodings and default widths for the projectile controller.
package projectile_pkg;
  localparam int POS_W_D  = 12;
  localparam int VEL_W_D  = 10;
  localparam int FRAC_W_D = 4;
  typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_DONE} state_e;
  typedef enum logic {M_STOP, M_BOUNCE} mode_e;
endpackage

// File: rtl/projectile_ctl_tick_gen.sv
// tick_gen: TICK_DIV prescaler, restarted by clr_i, counting only while en_i is high.
module tick_gen #(
  parameter int TICK_DIV = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt_q;
  assign tick_o = en_i && cnt_q == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i || tick_o) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + CW'(1);
endmodule

// File: rtl/projectile_ctl.sv
// projectile_ctl: fixed-point ballistic motion with wall reflection and ground stop/bounce.
module projectile_ctl
  import projectile_pkg::*;
#(
  parameter int POS_W    = POS_W_D,
  parameter int VEL_W    = VEL_W_D,
  parameter int FRAC_W   = FRAC_W_D,
  parameter int TICK_DIV = 65000,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 1023,
  parameter int Y_GROUND = 767,
  parameter int VY_STOP  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    mode_i,
  input  logic [POS_W-1:0]        x0_i,
  input  logic [POS_W-1:0]        y0_i,
  input  logic signed [VEL_W-1:0] vx0_i,
  input  logic signed [VEL_W-1:0] vy0_i,
  input  logic signed [VEL_W-1:0] grav_i,
  output logic [POS_W-1:0]        x_pos_o,
  output logic [POS_W-1:0]        y_pos_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    hit_wall_o
);
  localparam int PW = POS_W + FRAC_W + 1;
  localparam logic signed [PW-1:0] XLO = PW'(X_MIN << FRAC_W);
  localparam logic signed [PW-1:0] XHI = PW'(X_MAX << FRAC_W);
  localparam logic signed [PW-1:0] YG  = PW'(Y_GROUND << FRAC_W);
  localparam logic signed [VEL_W-1:0] VMAX  = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VMIN  = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] VSTOP = VEL_W'(VY_STOP);

  function automatic logic signed [VEL_W-1:0] sat_add(input logic signed [VEL_W-1:0] a,
                                                      input logic signed [VEL_W-1:0] b);
    logic [VEL_W:0] s;
    s = {a[VEL_W-1], a} + {b[VEL_W-1], b};
    return (s[VEL_W] != s[VEL_W-1]) ? (s[VEL_W] ? VMIN : VMAX) : s[VEL_W-1:0];
  endfunction

  state_e                  state_q;
  logic signed [PW-1:0]    x_q, y_q, x_s, y_s, x_n, y_n;
  logic signed [VEL_W-1:0] vx_q, vy_q, g_q, vx_n, vy_g, vy_b, vy_n;
  logic                    busy_q, done_q, hit_q;
  logic                    launch, tick, wall_lo, wall_hi, gnd, bounce, land;

  assign launch = state_q == S_IDLE && start_i && !abort_i;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (launch),
    .en_i   (state_q == S_FLIGHT),
    .tick_o (tick)
  );

  // Position advances with pre-tick velocities; the bounce halves the post-gravity vy.
  always_comb begin
    x_s     = x_q + PW'(vx_q);
    y_s     = y_q + PW'(vy_q);
    vy_g    = sat_add(vy_q, g_q);
    wall_lo = x_s < XLO;
    wall_hi = x_s > XHI;
    x_n     = wall_lo ? XLO : wall_hi ? XHI : x_s;
    vx_n    = (wall_lo || wall_hi) ? (vx_q == VMIN ? VMAX : -vx_q) : vx_q;
    gnd     = y_s >= YG;
    y_n     = gnd ? YG : y_s;
    vy_b    = -(vy_g >>> 1);
    bounce  = gnd && mode_e'(mode_i) == M_BOUNCE;
    vy_n    = bounce ? vy_b : vy_g;
    land    = gnd && (!bounce || (vy_b < VSTOP && vy_b > -VSTOP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      g_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (launch) begin
          state_q <= S_FLIGHT;
          busy_q  <= 1'b1;
          x_q     <= PW'({1'b0, x0_i}) << FRAC_W;
          y_q     <= PW'({1'b0, y0_i}) << FRAC_W;
          vx_q    <= vx0_i;
          vy_q    <= vy0_i;
          g_q     <= grav_i;
        end
        S_FLIGHT: if (abort_i) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else if (tick) begin
          x_q   <= x_n;
          y_q   <= y_n;
          vx_q  <= vx_n;
          vy_q  <= vy_n;
          hit_q <= wall_lo || wall_hi;
          if (land) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_pos_o    = POS_W'(x_q >>> FRAC_W);
  assign y_pos_o    = POS_W'(y_q >>> FRAC_W);
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign hit_wall_o = hit_q;
endmodule
